sync_fifo: RTL

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for paths where producer and consumer share one clock domain. It adds programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow and underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer block and a consumer block in one clock domain and exposes binary pointers for debug.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 33 +++
 rtl/sync_fifo.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO: read-mode selectors and default geometry.
package fifo_pkg;

  localparam int FWFT_OFF   = 0;
  localparam int FWFT_ON    = 1;

  localparam int DEF_PWIDTH = 4;
  localparam int DEF_DWIDTH = 8;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage, 2**PWIDTH x DWIDTH, with an asynchronous clear.
// Latency: write lands at the clock edge; read is combinational from raddr.
// Backpressure: none; the caller only asserts we for accepted writes.
module fifo_mem #(
  parameter int PWIDTH = fifo_pkg::DEF_PWIDTH,
  parameter int DWIDTH = fifo_pkg::DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [PWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** PWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with thresholds, occupancy, sticky errors and optional FWFT read.
// Latency: flags/count follow accepted ops by one cycle; std read data 1 cycle after r_acc.
// Backpressure: writes refused while full, reads refused while empty; refusals set sticky flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int PWIDTH    = DEF_PWIDTH,
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AFULL_TH  = 2 ** PWIDTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic              clr_err,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [PWIDTH-1:0] b_wptr,
  output logic [PWIDTH-1:0] b_rptr
);

  localparam logic [PWIDTH:0] PTR_ONE = (PWIDTH + 1)'(1);
  localparam logic [PWIDTH:0] AF_TH   = (PWIDTH + 1)'(AFULL_TH);
  localparam logic [PWIDTH:0] AE_TH   = (PWIDTH + 1)'(AEMPTY_TH);

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  logic [PWIDTH:0]   wptr;
  logic [PWIDTH:0]   rptr;
  logic              w_acc;
  logic              r_acc;
  logic [DWIDTH-1:0] rd_word;

  assign b_wptr = wptr[PWIDTH-1:0];
  assign b_rptr = rptr[PWIDTH-1:0];

  assign empty        = (wptr == rptr);
  assign full         = (wptr[PWIDTH] != rptr[PWIDTH]) && (b_wptr == b_rptr);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  assign w_acc = w_en && !full;
  assign r_acc = r_en && !empty;

  fifo_mem #(
    .PWIDTH (PWIDTH),
    .DWIDTH (DWIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_acc),
    .waddr (b_wptr),
    .wdata (data_in),
    .raddr (b_rptr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (w_acc) wptr <= wptr + PTR_ONE;
      if (r_acc) rptr <= rptr + PTR_ONE;
    end
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en && full)  || (overflow  && !clr_err);
      underflow <= (r_en && empty) || (underflow && !clr_err);
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign data_out = rd_word;
    end else begin : g_std
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_out <= '0;
        end else if (r_acc) begin
          data_out <= rd_word;
        end
      end
    end
  endgenerate

endmodule
